// File: rtl/spam_fabric_pkg.sv
// spam_fabric_pkg: shared SPAM bus widths and fabric FSM encoding
package spam_fabric_pkg;
    localparam int SPAM_DID_HI  = 3;
    localparam int SPAM_ADDR_HI = 15;
    localparam int SPAM_DATA_HI = 15;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} spam_state_e;
    function automatic int sel_width(input int devices);
        return (devices > 1) ? $clog2(devices) : 1;
    endfunction
endpackage

// File: rtl/spam_timeout_ctr.sv
// spam_timeout_ctr: WAIT-cycle counter, expired on the TIMEOUT-th enabled cycle
module spam_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
    assign expired = en && (cnt_q == W'(TIMEOUT - 1));
endmodule

// File: rtl/spam_fabric.sv
// spam_fabric: routes one master SPAM request at a time to a decoded device
// and returns its completion, or a decode/timeout error response.
module spam_fabric
    import spam_fabric_pkg::*;
#(
    parameter int SPAM_DEVICES = 4,
    parameter int DEV_SEL_LO   = 8,
    parameter int TIMEOUT      = 255
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     spamo_valid,
    input  logic                                     spamo_r_nw,
    input  logic [SPAM_DID_HI:0]                     spamo_did,
    input  logic [SPAM_ADDR_HI:0]                    spamo_addr,
    input  logic [SPAM_DATA_HI:0]                    spamo_data,
    output logic                                     spami_busy_b,
    output logic [SPAM_DATA_HI:0]                    spami_data,
    output logic [SPAM_DEVICES-1:0]                  dev_spamo_valids,
    output logic                                     dev_spamo_r_nw,
    output logic [SPAM_DID_HI:0]                     dev_spamo_did,
    output logic [SPAM_ADDR_HI:0]                    dev_spamo_addr,
    output logic [SPAM_DATA_HI:0]                    dev_spamo_data,
    input  logic [SPAM_DEVICES-1:0]                  dev_spami_busy_bs,
    input  logic [SPAM_DEVICES*(SPAM_DATA_HI+1)-1:0] dev_spami_datas,
    output logic                                     spam_err,
    output logic [SPAM_ADDR_HI:0]                    spam_err_addr,
    output logic                                     spam_overrun
);
    localparam int SEL_W = sel_width(SPAM_DEVICES);
    spam_state_e state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d, req_sel;
    logic r_nw_q, r_nw_d, busy_b_q, busy_b_d, err_q, err_d, overrun_q, overrun_d;
    logic [SPAM_DID_HI:0] did_q, did_d;
    logic [SPAM_ADDR_HI:0] addr_q, addr_d, err_addr_q, err_addr_d;
    logic [SPAM_DATA_HI:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [SPAM_DEVICES-1:0] valids_q, valids_d;
    logic dev_done, expired;
    assign req_sel  = spamo_addr[DEV_SEL_LO +: SEL_W];
    assign dev_done = dev_spami_busy_bs[sel_q];
    spam_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk(clk), .rst(rst), .clr(state_q == ST_ISSUE), .en(state_q == ST_WAIT), .expired(expired)
    );
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        r_nw_d     = r_nw_q;
        did_d      = did_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        valids_d   = '0;
        busy_b_d   = 1'b0;
        rdata_d    = '0;
        err_d      = 1'b0;
        err_addr_d = err_addr_q;
        overrun_d  = overrun_q | (spamo_valid && state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: if (spamo_valid) begin
                {r_nw_d, did_d, addr_d, wdata_d} = {spamo_r_nw, spamo_did, spamo_addr, spamo_data};
                sel_d = req_sel;
                if (int'(req_sel) < SPAM_DEVICES) begin
                    valids_d[req_sel] = 1'b1;
                    state_d = ST_ISSUE;
                end else state_d = ST_RESP;
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: if (dev_done || expired) begin
                state_d  = ST_RESP;
                busy_b_d = 1'b1;
                rdata_d  = dev_done ? dev_spami_datas[sel_q * (SPAM_DATA_HI + 1) +: SPAM_DATA_HI + 1] : '1;
                err_d    = !dev_done;
                err_addr_d = dev_done ? err_addr_q : addr_q;
            end
            default: begin
                // a decode error enters RESP with no pulse yet and emits it one cycle later
                state_d    = busy_b_q ? ST_IDLE : ST_RESP;
                busy_b_d   = !busy_b_q;
                err_d      = !busy_b_q;
                err_addr_d = busy_b_q ? err_addr_q : addr_q;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            r_nw_q     <= 1'b0;
            did_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            valids_q   <= '0;
            busy_b_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            r_nw_q     <= r_nw_d;
            did_q      <= did_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            valids_q   <= valids_d;
            busy_b_q   <= busy_b_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
            overrun_q  <= overrun_d;
        end
    end
    assign spami_busy_b     = busy_b_q;
    assign spami_data       = rdata_q;
    assign dev_spamo_valids = valids_q;
    assign dev_spamo_r_nw   = r_nw_q;
    assign dev_spamo_did    = did_q;
    assign dev_spamo_addr   = addr_q;
    assign dev_spamo_data   = wdata_q;
    assign spam_err         = err_q;
    assign spam_err_addr    = err_addr_q;
    assign spam_overrun     = overrun_q;
endmodule

// File: tb/tb_spam_fabric.sv
// tb_spam_fabric: directed requests with a completion scoreboard per fabric instance
module tb_spam_fabric;
    import spam_fabric_pkg::*;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic spamo_valid = 1'b0, spamo_valid3 = 1'b0, spamo_r_nw = 1'b0;
    logic [SPAM_DID_HI:0] spamo_did = '0;
    logic [SPAM_ADDR_HI:0] spamo_addr = '0;
    logic [SPAM_DATA_HI:0] spamo_data = '0;
    logic spami_busy_b, spam_err, spam_overrun, dev_r_nw;
    logic [15:0] spami_data, spam_err_addr, dev_addr, dev_data;
    logic [3:0] dev_did, valids;
    logic [3:0] dev_busy = '0;
    logic [63:0] dev_datas = '0;
    logic busy3, err3, ovr3, r_nw3;
    logic [15:0] data3, eaddr3, addr3, wdata3;
    logic [3:0] did3;
    logic [2:0] valids3;
    logic [2:0] dev_busy3 = '0;
    logic [47:0] dev_datas3 = '0;

    spam_fabric #(.SPAM_DEVICES(4), .DEV_SEL_LO(8), .TIMEOUT(8)) u_dut (
        .clk(clk), .rst(rst), .spamo_valid(spamo_valid), .spamo_r_nw(spamo_r_nw),
        .spamo_did(spamo_did), .spamo_addr(spamo_addr), .spamo_data(spamo_data),
        .spami_busy_b(spami_busy_b), .spami_data(spami_data), .dev_spamo_valids(valids),
        .dev_spamo_r_nw(dev_r_nw), .dev_spamo_did(dev_did), .dev_spamo_addr(dev_addr),
        .dev_spamo_data(dev_data), .dev_spami_busy_bs(dev_busy), .dev_spami_datas(dev_datas),
        .spam_err(spam_err), .spam_err_addr(spam_err_addr), .spam_overrun(spam_overrun)
    );
    spam_fabric #(.SPAM_DEVICES(3), .DEV_SEL_LO(8), .TIMEOUT(8)) u_dut3 (
        .clk(clk), .rst(rst), .spamo_valid(spamo_valid3), .spamo_r_nw(spamo_r_nw),
        .spamo_did(spamo_did), .spamo_addr(spamo_addr), .spamo_data(spamo_data),
        .spami_busy_b(busy3), .spami_data(data3), .dev_spamo_valids(valids3),
        .dev_spamo_r_nw(r_nw3), .dev_spamo_did(did3), .dev_spamo_addr(addr3),
        .dev_spamo_data(wdata3), .dev_spami_busy_bs(dev_busy3), .dev_spami_datas(dev_datas3),
        .spam_err(err3), .spam_err_addr(eaddr3), .spam_overrun(ovr3)
    );

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic [15:0] eaddr;
        int          t;
        int          lat;
    } exp_t;
    exp_t q4[$], q3[$];
    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // latency is counted from the cycle the request was sampled to the completion cycle
    always @(negedge clk) if (spami_busy_b) begin
        exp_t e;
        if (q4.size() == 0) chk("dut4_unexpected_completion", q4.size(), 1);
        else begin
            e = q4.pop_front();
            chk("dut4_data", 32'(spami_data), 32'(e.data));
            chk("dut4_err", 32'(spam_err), 32'(e.err));
            chk("dut4_latency", cyc + 1 - e.t, e.lat);
            if (e.err) chk("dut4_err_addr", 32'(spam_err_addr), 32'(e.eaddr));
        end
    end
    always @(negedge clk) if (busy3) begin
        exp_t e;
        if (q3.size() == 0) chk("dut3_unexpected_completion", q3.size(), 1);
        else begin
            e = q3.pop_front();
            chk("dut3_data", 32'(data3), 32'(e.data));
            chk("dut3_err", 32'(err3), 32'(e.err));
            chk("dut3_latency", cyc + 1 - e.t, e.lat);
            if (e.err) chk("dut3_err_addr", 32'(eaddr3), 32'(e.eaddr));
        end
    end

    task automatic issue(input bit to3, input logic rnw, input logic [15:0] a, input logic [15:0] d, output int t);
        @(negedge clk);
        spamo_r_nw = rnw;
        spamo_addr = a;
        spamo_data = d;
        spamo_did  = 4'h5;
        if (to3) spamo_valid3 = 1'b1;
        else spamo_valid = 1'b1;
        @(posedge clk);
        #1;
        t = cyc;
        spamo_valid  = 1'b0;
        spamo_valid3 = 1'b0;
    endtask

    task automatic wait_strobe(input logic [3:0] want);
        int n = 0;
        @(negedge clk);
        while (valids == 4'b0 && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk("strobe_onehot", 32'(valids), 32'(want));
    endtask

    task automatic pulse(input int dev, input logic [15:0] d);
        dev_busy[dev] = 1'b1;
        dev_datas[dev*16 +: 16] = d;
        @(negedge clk);
        dev_busy[dev] = 1'b0;
    endtask

    task automatic chk_reset();
        chk("rst_busy_b", 32'(spami_busy_b), 0);
        chk("rst_data", 32'(spami_data), 0);
        chk("rst_valids", 32'(valids), 0);
        chk("rst_err", 32'(spam_err), 0);
        chk("rst_err_addr", 32'(spam_err_addr), 0);
        chk("rst_overrun", 32'(spam_overrun), 0);
        chk("rst_req_addr", 32'(dev_addr), 0);
        chk("rst_req_data", 32'(dev_data), 0);
        chk("rst_req_ctl", 32'({dev_r_nw, dev_did}), 0);
    endtask

    initial begin
        int t;
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b0;
        @(negedge clk);
        pulse(2, 16'h1111);
        // read from device 1, completion 3 cycles after the strobe
        issue(0, 1'b1, 16'h0104, 16'h0000, t);
        q4.push_back('{16'hCAFE, 1'b0, 16'h0, t, 5});
        chk("req_addr", 32'(dev_addr), 32'h0104);
        chk("req_r_nw", 32'(dev_r_nw), 1);
        wait_strobe(4'b0010);
        @(negedge clk);
        chk("strobe_one_cycle", 32'(valids), 0);
        repeat (2) @(negedge clk);
        pulse(1, 16'hCAFE);
        repeat (3) @(negedge clk);
        // write, fastest device completion
        issue(0, 1'b0, 16'h0230, 16'h1234, t);
        q4.push_back('{16'hBEEF, 1'b0, 16'h0, t, 3});
        chk("req_wdata", 32'(dev_data), 32'h1234);
        chk("req_w_r_nw", 32'(dev_r_nw), 0);
        wait_strobe(4'b0100);
        @(negedge clk);
        pulse(2, 16'hBEEF);
        repeat (3) @(negedge clk);
        // unselected device completes first and must be ignored
        issue(0, 1'b1, 16'h0300, 16'h0000, t);
        q4.push_back('{16'h0F0F, 1'b0, 16'h0, t, 4});
        wait_strobe(4'b1000);
        @(negedge clk);
        pulse(0, 16'hDEAD);
        pulse(3, 16'h0F0F);
        repeat (3) @(negedge clk);
        // timeout, then a late completion
        issue(0, 1'b1, 16'h0100, 16'h0000, t);
        q4.push_back('{16'hFFFF, 1'b1, 16'h0100, t, 10});
        wait_strobe(4'b0010);
        repeat (9) @(negedge clk);
        pulse(1, 16'h5555);
        repeat (3) @(negedge clk);
        // completion in the same cycle as expiry wins
        issue(0, 1'b1, 16'h0200, 16'h0000, t);
        q4.push_back('{16'hA5A5, 1'b0, 16'h0, t, 10});
        wait_strobe(4'b0100);
        repeat (8) @(negedge clk);
        pulse(2, 16'hA5A5);
        repeat (3) @(negedge clk);
        // second request during WAIT is dropped
        chk("overrun_clear", 32'(spam_overrun), 0);
        issue(0, 1'b1, 16'h0104, 16'h0000, t);
        q4.push_back('{16'h7777, 1'b0, 16'h0, t, 4});
        wait_strobe(4'b0010);
        @(negedge clk);
        spamo_valid = 1'b1;
        spamo_addr  = 16'h0300;
        @(negedge clk);
        spamo_valid = 1'b0;
        pulse(1, 16'h7777);
        repeat (3) @(negedge clk);
        chk("overrun_set", 32'(spam_overrun), 1);
        chk("overrun_addr_kept", 32'(dev_addr), 32'h0104);
        // decode error on the three-device fabric
        issue(1'b1, 1'b1, 16'h0300, 16'h0000, t);
        q3.push_back('{16'h0000, 1'b1, 16'h0300, t, 2});
        chk("dut3_no_strobe", 32'(valids3), 0);
        @(negedge clk);
        chk("dut3_no_strobe2", 32'(valids3), 0);
        repeat (3) @(negedge clk);
        chk("overrun_sticky", 32'(spam_overrun), 1);
        // reset during WAIT abandons the transaction
        issue(0, 1'b1, 16'h0104, 16'h0000, t);
        wait_strobe(4'b0010);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset();
        pulse(1, 16'h9999);
        repeat (2) @(negedge clk);
        issue(0, 1'b1, 16'h0330, 16'h0000, t);
        q4.push_back('{16'h4242, 1'b0, 16'h0, t, 4});
        wait_strobe(4'b1000);
        repeat (2) @(negedge clk);
        pulse(3, 16'h4242);
        repeat (5) @(negedge clk);
        chk("dut4_pending", q4.size(), 0);
        chk("dut3_pending", q3.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
